// File: rtl/instr_fetch_unit.sv
// Fetch stage of the pocket-calculator core.
// Owns the program counter and drives the instruction ROM address. Each fetched
// word is registered together with its address for decode/ALU.
// Handles taken-branch redirects with a one-cycle bubble and downstream stalls.
// The core stops on the HALT word or on a fetch beyond the end of the ROM.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          AW        = 8,
    parameter int          ROM_DEPTH = 256,
    parameter logic [15:0] HALT_WORD = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          branch_taken,
    input  logic [15:0]   branch_target,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_data,
    output logic [15:0]   pc,
    output logic [15:0]   inst,
    output logic          inst_valid,
    output logic          halted,
    output logic          fault
);

    typedef enum logic [1:0] {
        S_START,
        S_RUN,
        S_HALT
    } state_t;

    // One bit wider than the PC so that a depth of 65536 words is expressible.
    localparam logic [16:0] ROM_LIMIT = 17'(ROM_DEPTH);

    state_t      state;
    logic [15:0] fetch_pc;
    logic        out_of_range;
    logic        is_halt_word;

    // The ROM address is the only output allowed to follow fetch_pc directly.
    assign imem_addr    = fetch_pc[AW-1:0];
    assign out_of_range = {1'b0, fetch_pc} >= ROM_LIMIT;
    assign is_halt_word = (imem_data == HALT_WORD);

    // Fetch FSM: program counter, output registers and halt/fault tracking.
    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge value of every other register, exactly like the hardware.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_START;
            fetch_pc   <= RESET_PC;
            pc         <= 16'h0000;
            inst       <= 16'h0000;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    // ROM is addressed at RESET_PC this cycle; the first
                    // capture happens in the first RUN cycle.
                    state <= S_RUN;
                end

                S_RUN: begin
                    if (branch_taken) begin
                        // Redirect wins over stall; the word in flight is
                        // dropped and inst/pc keep their old values.
                        fetch_pc   <= branch_target;
                        inst_valid <= 1'b0;
                    end else if (stall) begin
                        // Downstream busy: every register holds.
                        state <= S_RUN;
                    end else if (out_of_range) begin
                        state      <= S_HALT;
                        halted     <= 1'b1;
                        fault      <= 1'b1;
                        inst_valid <= 1'b0;
                    end else begin
                        inst       <= imem_data;
                        pc         <= fetch_pc;
                        inst_valid <= 1'b1;
                        fetch_pc   <= fetch_pc + 16'd1;
                        // The HALT word is still presented for one cycle.
                        if (is_halt_word) begin
                            state <= S_HALT;
                        end
                    end
                end

                S_HALT: begin
                    // Terminal until reset; branch and stall are ignored.
                    halted     <= 1'b1;
                    inst_valid <= 1'b0;
                end

                default: begin
                    state      <= S_HALT;
                    halted     <= 1'b1;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
